// File: rtl/wb_arbiter_pkg.sv
// Shared defines for the writeback arbiter: FU count, epoch width and the queue payload.
package wb_arbiter_pkg;

  localparam int unsigned FU_NUM        = 4;
  localparam int unsigned EPOCH_W       = 2;
  localparam int unsigned FU_W          = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int unsigned PHYS_REGS_DEF = 64;
  localparam int unsigned DW_DEF        = 32;
  localparam int unsigned PHYS_W_DEF    = $clog2(PHYS_REGS_DEF);

  typedef struct packed {
    logic [PHYS_W_DEF-1:0] pd;
    logic [DW_DEF-1:0]     data;
    logic [EPOCH_W-1:0]    epoch;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// FU result inputs, flush control and PRF writeback port of the arbiter.
interface wb_arbiter_if #(
  parameter int unsigned PHYS_W = 6,
  parameter int unsigned DW     = 32
) ();
  import wb_arbiter_pkg::*;

  logic [FU_NUM-1:0]  fu_valid;
  logic [FU_NUM-1:0]  fu_ready;
  logic [PHYS_W-1:0]  fu_pd    [FU_NUM];
  logic [DW-1:0]      fu_data  [FU_NUM];
  logic [EPOCH_W-1:0] fu_epoch [FU_NUM];
  logic               flush_valid;
  logic [EPOCH_W-1:0] flush_epoch;
  logic               wb_valid;
  logic               wb_ready;
  logic [PHYS_W-1:0]  wb_pd;
  logic [DW-1:0]      wb_data;
  logic [EPOCH_W-1:0] wb_epoch;
  logic [FU_W-1:0]    wb_fu_id;
  logic               pending;

  modport master (
    output fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
    input  fu_ready, wb_valid, wb_pd, wb_data, wb_epoch, wb_fu_id, pending
  );

  modport slave (
    input  fu_valid, fu_pd, fu_data, fu_epoch, flush_valid, flush_epoch, wb_ready,
    output fu_ready, wb_valid, wb_pd, wb_data, wb_epoch, wb_fu_id, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-FU result queue; head always sits in slot 0 so epoch flushes compact in order.
module wb_fifo #(
  parameter int unsigned PHYS_W  = 6,
  parameter int unsigned DW      = 32,
  parameter int unsigned EPOCH_W = 2,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [PHYS_W-1:0]  push_pd,
  input  logic [DW-1:0]      push_data,
  input  logic [EPOCH_W-1:0] push_epoch,
  input  logic               pop,
  input  logic               flush_valid,
  input  logic [EPOCH_W-1:0] flush_epoch,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      count_nxt_c,
  output logic [PHYS_W-1:0]  head_pd,
  output logic [DW-1:0]      head_data,
  output logic [EPOCH_W-1:0] head_epoch
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PHYS_W-1:0]  pd;
    logic [DW-1:0]      data;
    logic [EPOCH_W-1:0] epoch;
  } entry_t;

  entry_t        mem     [DEPTH];
  entry_t        mem_nxt [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  // Survivors (not popped, not stale) slide down in order, then the push lands behind them.
  always_comb begin
    mem_nxt = mem;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt_q) && !(pop && (i == 0)) &&
          !(flush_valid && (mem[i].epoch != flush_epoch))) begin
        mem_nxt[IW'(cnt_nxt)] = mem[i];
        cnt_nxt               = cnt_nxt + CW'(1);
      end
    end
    if (push && !(flush_valid && (push_epoch != flush_epoch)) && (cnt_nxt < CW'(DEPTH))) begin
      mem_nxt[IW'(cnt_nxt)] = '{pd: push_pd, data: push_data, epoch: push_epoch};
      cnt_nxt               = cnt_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_nxt;
  end

  // Storage is qualified by the count, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
  end

  assign count       = cnt_q;
  assign count_nxt_c = cnt_nxt;
  assign head_pd     = mem[0].pd;
  assign head_data   = mem[0].data;
  assign head_epoch  = mem[0].epoch;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: FU_NUM result queues feeding one registered PRF write slot.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned DW        = 32,
  parameter int unsigned PHYS_W    = $clog2(PHYS_REGS),
  parameter int unsigned DEPTH     = 2
) (
  input logic        clk,
  input logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]      fifo_cnt     [FU_NUM];
  logic [CW-1:0]      fifo_cnt_nxt [FU_NUM];
  logic [PHYS_W-1:0]  head_pd      [FU_NUM];
  logic [DW-1:0]      head_data    [FU_NUM];
  logic [EPOCH_W-1:0] head_epoch   [FU_NUM];
  logic [FU_NUM-1:0]  push, pop, eligible;
  logic [FU_NUM-1:0]  ready_q, ready_nxt;
  logic               pending_q, pending_nxt;

  logic               slot_valid_q, slot_valid_nxt;
  logic [PHYS_W-1:0]  slot_pd_q,    slot_pd_nxt;
  logic [DW-1:0]      slot_data_q,  slot_data_nxt;
  logic [EPOCH_W-1:0] slot_epoch_q, slot_epoch_nxt;
  logic [FU_W-1:0]    slot_fu_q,    slot_fu_nxt;
  logic [FU_W-1:0]    rr_q,         rr_nxt;

  logic               load_en;
  logic               grant_valid;
  logic [FU_W-1:0]    grant_id;
  logic [FU_W-1:0]    idx;

  for (genvar g = 0; g < FU_NUM; g++) begin : g_fu
    wb_fifo #(
      .PHYS_W  (PHYS_W),
      .DW      (DW),
      .EPOCH_W (EPOCH_W),
      .DEPTH   (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push[g]),
      .push_pd     (bus.fu_pd[g]),
      .push_data   (bus.fu_data[g]),
      .push_epoch  (bus.fu_epoch[g]),
      .pop         (pop[g]),
      .flush_valid (bus.flush_valid),
      .flush_epoch (bus.flush_epoch),
      .count       (fifo_cnt[g]),
      .count_nxt_c (fifo_cnt_nxt[g]),
      .head_pd     (head_pd[g]),
      .head_data   (head_data[g]),
      .head_epoch  (head_epoch[g])
    );
  end

  // A head is grantable only if it survives any flush happening this cycle.
  always_comb begin
    push     = '0;
    eligible = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      push[i]     = bus.fu_valid[i] & ready_q[i];
      eligible[i] = (fifo_cnt[i] != '0) &&
                    (!bus.flush_valid || (head_epoch[i] == bus.flush_epoch));
    end
  end

  // Round-robin search starting at rr_q, wrapping modulo FU_NUM.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int k = 0; k < FU_NUM; k++) begin
      idx = ((int'(rr_q) + k) >= FU_NUM) ? FU_W'(int'(rr_q) + k - FU_NUM)
                                          : FU_W'(int'(rr_q) + k);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign load_en = !slot_valid_q || bus.wb_ready;

  // Slot next-state: reload on empty/transfer, otherwise hold unless flushed as stale.
  always_comb begin
    slot_valid_nxt = slot_valid_q;
    slot_pd_nxt    = slot_pd_q;
    slot_data_nxt  = slot_data_q;
    slot_epoch_nxt = slot_epoch_q;
    slot_fu_nxt    = slot_fu_q;
    rr_nxt         = rr_q;
    pop            = '0;
    if (load_en) begin
      slot_valid_nxt = grant_valid;
      if (grant_valid) begin
        slot_pd_nxt    = head_pd[grant_id];
        slot_data_nxt  = head_data[grant_id];
        slot_epoch_nxt = head_epoch[grant_id];
        slot_fu_nxt    = grant_id;
        pop[grant_id]  = 1'b1;
        rr_nxt         = (grant_id == FU_W'(FU_NUM - 1)) ? '0 : grant_id + FU_W'(1);
      end
    end else if (bus.flush_valid && (slot_epoch_q != bus.flush_epoch)) begin
      slot_valid_nxt = 1'b0;
    end
  end

  // ready and pending are registered from next-state so they mirror the registered counts.
  always_comb begin
    ready_nxt   = '0;
    pending_nxt = slot_valid_nxt;
    for (int i = 0; i < FU_NUM; i++) begin
      ready_nxt[i] = fifo_cnt_nxt[i] < CW'(DEPTH);
      pending_nxt  = pending_nxt | (fifo_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_pd_q    <= '0;
      slot_data_q  <= '0;
      slot_epoch_q <= '0;
      slot_fu_q    <= '0;
      rr_q         <= '0;
      ready_q      <= '1;
      pending_q    <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_nxt;
      slot_pd_q    <= slot_pd_nxt;
      slot_data_q  <= slot_data_nxt;
      slot_epoch_q <= slot_epoch_nxt;
      slot_fu_q    <= slot_fu_nxt;
      rr_q         <= rr_nxt;
      ready_q      <= ready_nxt;
      pending_q    <= pending_nxt;
    end
  end

  assign bus.wb_valid = slot_valid_q;
  assign bus.wb_pd    = slot_pd_q;
  assign bus.wb_data  = slot_data_q;
  assign bus.wb_epoch = slot_epoch_q;
  assign bus.wb_fu_id = slot_fu_q;
  assign bus.fu_ready = ready_q;
  assign bus.pending  = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writebacks are queued at stimulus, checked by a monitor.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int unsigned PW  = 6;
  localparam int unsigned DWT = 32;

  typedef struct packed {
    logic [FU_W-1:0]    fu;
    logic [PW-1:0]      pd;
    logic [DWT-1:0]     data;
    logic [EPOCH_W-1:0] epoch;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  exp_t mon_got;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.PHYS_W(PW), .DW(DWT)) bus ();

  wb_arbiter #(.PHYS_REGS(64), .DW(DWT), .PHYS_W(PW), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      mon_got = '{fu: bus.wb_fu_id, pd: bus.wb_pd, data: bus.wb_data, epoch: bus.wb_epoch};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got %0h want none", mon_got);
      end else begin
        chk("wb_entry", 64'(mon_got), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fu_valid    = '0;
    bus.flush_valid = 1'b0;
    bus.flush_epoch = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      bus.fu_pd[i]    = '0;
      bus.fu_data[i]  = '0;
      bus.fu_epoch[i] = '0;
    end
  endtask

  task automatic drive_fu(input logic [FU_W-1:0] i, input logic [PW-1:0] pd,
                          input logic [DWT-1:0] d, input logic [EPOCH_W-1:0] ep,
                          input bit expect_it);
    bus.fu_valid[i] = 1'b1;
    bus.fu_pd[i]    = pd;
    bus.fu_data[i]  = d;
    bus.fu_epoch[i] = ep;
    if (expect_it) exp_q.push_back('{fu: i, pd: pd, data: d, epoch: ep});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'(0));
    chk({tag, "_wb_fields"}, 64'({bus.wb_fu_id, bus.wb_pd, bus.wb_data, bus.wb_epoch}), 64'(0));
    chk({tag, "_fu_ready"}, 64'(bus.fu_ready), 64'(4'hF));
    chk({tag, "_pending"}, 64'(bus.pending), 64'(0));
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.wb_ready = 1'b0;
    idle_inputs();
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    bus.wb_ready = 1'b0;

    // Single result: push in cycle t, visible in t+2 for one cycle.
    apply_reset();
    bus.wb_ready = 1'b1;
    drive_fu(2'd0, 6'd5, 32'hDEAD, 2'd0, 1'b1);
    tick();
    idle_inputs();
    chk("single_t1_valid", 64'(bus.wb_valid), 64'(0));
    chk("single_t1_pending", 64'(bus.pending), 64'(1));
    tick();
    chk("single_t2_valid", 64'(bus.wb_valid), 64'(1));
    chk("single_t2_pd_fu", 64'({bus.wb_pd, bus.wb_fu_id}), 64'({6'd5, 2'd0}));
    tick();
    chk("single_t3_valid", 64'(bus.wb_valid), 64'(0));
    chk("single_t3_pending", 64'(bus.pending), 64'(0));

    // Round-robin from reset: 0,1,2,3 back to back, then 1,3.
    apply_reset();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < FU_NUM; i++)
      drive_fu(FU_W'(i), PW'(10 + i), DWT'(32'h1000 + i), 2'd0, 1'b1);
    tick();
    idle_inputs();
    tick();
    for (int k = 0; k < FU_NUM; k++) begin
      chk("rr_valid", 64'(bus.wb_valid), 64'(1));
      chk("rr_fu_id", 64'(bus.wb_fu_id), 64'(k));
      tick();
    end
    chk("rr_drained", 64'(bus.wb_valid), 64'(0));
    drive_fu(2'd1, 6'd14, 32'h2001, 2'd0, 1'b1);
    drive_fu(2'd3, 6'd15, 32'h2003, 2'd0, 1'b1);
    tick();
    idle_inputs();
    tick();
    chk("rr2_first", 64'(bus.wb_fu_id), 64'(1));
    tick();
    chk("rr2_second", 64'(bus.wb_fu_id), 64'(3));
    tick();
    chk("rr2_drained", 64'(bus.wb_valid), 64'(0));

    // Backpressure on FU2: slot holds A, queue fills with B,C, a fourth push is refused.
    bus.wb_ready = 1'b0;
    chk("bp_ready_c0", 64'(bus.fu_ready[2]), 64'(1));
    drive_fu(2'd2, 6'd20, 32'hA000_0001, 2'd0, 1'b1);
    tick();
    chk("bp_ready_c1", 64'(bus.fu_ready[2]), 64'(1));
    drive_fu(2'd2, 6'd21, 32'hB000_0002, 2'd0, 1'b1);
    tick();
    chk("bp_ready_c2", 64'(bus.fu_ready[2]), 64'(1));
    drive_fu(2'd2, 6'd22, 32'hC000_0003, 2'd0, 1'b1);
    tick();
    drive_fu(2'd2, 6'd23, 32'hD000_0004, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_full_ready", 64'(bus.fu_ready[2]), 64'(0));
      chk("bp_hold", 64'({bus.wb_valid, bus.wb_fu_id, bus.wb_pd, bus.wb_data, bus.wb_epoch}),
          64'({1'b1, 2'd2, 6'd20, 32'hA000_0001, 2'd0}));
      tick();
      if (k == 1) idle_inputs();
    end
    bus.wb_ready = 1'b1;
    repeat (5) tick();
    chk("bp_pending", 64'(bus.pending), 64'(0));

    // Flush: slot holds stale X, FU1 holds {Y ep0, Z ep1}, stale push W in flush cycle.
    bus.wb_ready = 1'b0;
    drive_fu(2'd1, 6'd30, 32'h0000_0030, 2'd0, 1'b0);
    tick();
    drive_fu(2'd1, 6'd31, 32'h0000_0031, 2'd0, 1'b0);
    tick();
    drive_fu(2'd1, 6'd32, 32'h0000_0032, 2'd1, 1'b1);
    tick();
    idle_inputs();
    chk("fl_slot_before", 64'({bus.wb_valid, bus.wb_pd, bus.wb_epoch}), 64'({1'b1, 6'd30, 2'd0}));
    chk("fl_fu1_full", 64'(bus.fu_ready[1]), 64'(0));
    bus.flush_valid = 1'b1;
    bus.flush_epoch = 2'd1;
    drive_fu(2'd0, 6'd33, 32'h0000_0033, 2'd0, 1'b0);
    tick();
    idle_inputs();
    chk("fl_slot_cleared", 64'(bus.wb_valid), 64'(0));
    chk("fl_ready", 64'(bus.fu_ready), 64'(4'hF));
    chk("fl_pending", 64'(bus.pending), 64'(1));
    bus.wb_ready = 1'b1;
    tick();
    chk("fl_survivor", 64'({bus.wb_valid, bus.wb_pd}), 64'({1'b1, 6'd32}));
    tick();
    chk("fl_drained", 64'(bus.pending), 64'(0));

    // Flush during a transfer: the outgoing entry still counts, a matching push survives.
    drive_fu(2'd3, 6'd40, 32'h0000_0040, 2'd1, 1'b1);
    tick();
    idle_inputs();
    tick();
    bus.flush_valid = 1'b1;
    bus.flush_epoch = 2'd2;
    drive_fu(2'd0, 6'd41, 32'h0000_0041, 2'd2, 1'b1);
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("flx_drained", 64'(bus.pending), 64'(0));

    // Asynchronous reset in the middle of a stall.
    bus.wb_ready = 1'b0;
    drive_fu(2'd0, 6'd50, 32'h0000_0050, 2'd0, 1'b0);
    drive_fu(2'd1, 6'd51, 32'h0000_0051, 2'd0, 1'b0);
    drive_fu(2'd2, 6'd52, 32'h0000_0052, 2'd0, 1'b0);
    tick();
    idle_inputs();
    repeat (2) tick();
    chk("rst_stall_valid", 64'(bus.wb_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    tick();
    rst_n        = 1'b1;
    bus.wb_ready = 1'b1;
    repeat (6) tick();
    chk("rst_after_valid", 64'(bus.wb_valid), 64'(0));
    chk("rst_after_pending", 64'(bus.pending), 64'(0));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
